// File: rtl/uart_encoder.sv
// uart_encoder: FIFO-buffered UART transmitter producing 8N1/8E1/8O1 frames with 1 or 2 stop bits.
module uart_encoder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic                         uart_tx_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR_BIT = 3'd3, STOP = 3'd4;
  logic [2:0]    state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shift;
  logic          push, pop, bit_end, last_stop, par_bit;
  always_comb begin
    bit_end   = baud == BW'(CLKS_PER_BIT - 1);
    last_stop = state == STOP && bit_end && stop_idx == 1'(STOP_BITS - 1);
    push      = valid_i && ready_o;
    pop       = fifo_count_o != '0 && (state == IDLE || last_stop);
    par_bit   = PARITY == 1 ? ~^shift : ^shift;
  end
  assign ready_o      = fifo_count_o != (AW+1)'(FIFO_DEPTH);
  assign busy_o       = state != IDLE;
  assign frame_done_o = last_stop;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_i;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      uart_tx_o    <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      baud         <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shift        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) fifo_count_o <= fifo_count_o + 1'b1;
      else if (pop && !push) fifo_count_o <= fifo_count_o - 1'b1;
      baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      // a pop also covers the back-to-back case at the end of the last stop bit
      if (pop) begin
        shift     <= mem[rd_ptr];
        bit_idx   <= '0;
        state     <= START;
        uart_tx_o <= 1'b0;
      end else if (state != IDLE && bit_end) begin
        case (state)
          START: begin
            state     <= DATA;
            uart_tx_o <= shift[0];
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              state     <= PARITY != 0 ? PAR_BIT : STOP;
              uart_tx_o <= PARITY != 0 ? par_bit : 1'b1;
              stop_idx  <= 1'b0;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              uart_tx_o <= shift[bit_idx + 3'd1];
            end
          end
          PAR_BIT: begin
            state     <= STOP;
            uart_tx_o <= 1'b1;
            stop_idx  <= 1'b0;
          end
          STOP: begin
            if (last_stop) begin
              state     <= IDLE;
              uart_tx_o <= 1'b1;
            end else stop_idx <= 1'b1;
          end
          default: begin
            state     <= IDLE;
            uart_tx_o <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_encoder.sv
// tb_uart_encoder: three encoder configurations checked each cycle against a queue-based line model.
module tb_uart_encoder;
  localparam int DEPTH = 4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data [3];
  logic [2:0] valid;
  logic [2:0] ready, tx, busy, done;
  logic [2:0] cnt0, cnt1, cnt2;
  int         total = 0;
  int         bad = 0;
  int         cpb [3];
  int         par [3];
  int         sb [3];
  logic [7:0] mq [3][$];
  bit         ml [3][$];
  bit         e_tx [3], e_busy [3], e_done [3], acc [3];
  int         e_cnt [3];

  always #5 clk = ~clk;

  uart_encoder #(.CLKS_PER_BIT(4), .FIFO_DEPTH(DEPTH), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .data_i(data[0]), .valid_i(valid[0]), .ready_o(ready[0]),
    .uart_tx_o(tx[0]), .busy_o(busy[0]), .frame_done_o(done[0]), .fifo_count_o(cnt0));
  uart_encoder #(.CLKS_PER_BIT(3), .FIFO_DEPTH(DEPTH), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .data_i(data[1]), .valid_i(valid[1]), .ready_o(ready[1]),
    .uart_tx_o(tx[1]), .busy_o(busy[1]), .frame_done_o(done[1]), .fifo_count_o(cnt1));
  uart_encoder #(.CLKS_PER_BIT(5), .FIFO_DEPTH(DEPTH), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .data_i(data[2]), .valid_i(valid[2]), .ready_o(ready[2]),
    .uart_tx_o(tx[2]), .busy_o(busy[2]), .frame_done_o(done[2]), .fifo_count_o(cnt2));

  task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s u%0d observed=%0h expected=%0h at %0t", tag, i, obs, exp, $time);
    end
  endtask

  // Whole frame is laid out as a list of line levels, one entry per clock cycle.
  task automatic add_frame(input int i, input logic [7:0] b);
    for (int c = 0; c < cpb[i]; c++) ml[i].push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < cpb[i]; c++) ml[i].push_back(b[k]);
    if (par[i] != 0)
      for (int c = 0; c < cpb[i]; c++) ml[i].push_back(par[i] == 2 ? ^b : ~^b);
    for (int c = 0; c < sb[i] * cpb[i]; c++) ml[i].push_back(1'b1);
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        ml[i].delete();
        acc[i] = 1'b0;
      end else begin
        acc[i] = valid[i] && mq[i].size() != DEPTH;
        if (ml[i].size() == 0 && mq[i].size() != 0) add_frame(i, mq[i].pop_front());
        if (acc[i]) mq[i].push_back(data[i]);
      end
      if (ml[i].size() != 0) begin
        e_tx[i]   = ml[i].pop_front();
        e_busy[i] = 1'b1;
        e_done[i] = ml[i].size() == 0;
      end else begin
        e_tx[i]   = 1'b1;
        e_busy[i] = 1'b0;
        e_done[i] = 1'b0;
      end
      e_cnt[i] = mq[i].size();
    end
  endtask

  task automatic check_all();
    logic [2:0] c;
    for (int i = 0; i < 3; i++) begin
      c = i == 0 ? cnt0 : i == 1 ? cnt1 : cnt2;
      chk("tx", i, {7'b0, tx[i]}, {7'b0, e_tx[i]});
      chk("busy", i, {7'b0, busy[i]}, {7'b0, e_busy[i]});
      chk("frame_done", i, {7'b0, done[i]}, {7'b0, e_done[i]});
      chk("fifo_count", i, {5'b0, c}, 8'(e_cnt[i]));
      chk("ready", i, {7'b0, ready[i]}, {7'b0, e_cnt[i] != DEPTH});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic push_one(input int i, input logic [7:0] b);
    int n = 0;
    valid[i] = 1'b1;
    data[i] = b;
    do begin
      cycle();
      n++;
    end while (!acc[i] && n < 400);
    valid[i] = 1'b0;
  endtask

  initial begin
    cpb = '{4, 3, 5};
    par = '{0, 2, 1};
    sb  = '{1, 2, 1};
    rst_n = 1'b0;
    valid = '0;
    data = '{8'h00, 8'h00, 8'h00};
    repeat (3) cycle();
    chk("reset_tx", 0, {7'b0, tx[0]}, 8'd1);
    chk("reset_count", 0, {5'b0, cnt0}, 8'd0);
    rst_n = 1'b1;
    cycle();
    push_one(0, 8'h55);
    repeat (45) cycle();
    valid[0] = 1'b1;
    data[0] = 8'h41;
    cycle();
    data[0] = 8'h0A;
    cycle();
    valid[0] = 1'b0;
    repeat (90) cycle();
    for (int j = 0; j < 6; j++) push_one(0, 8'h30 + 8'(j));
    repeat (260) cycle();
    valid[1] = 1'b1;
    data[1] = 8'h07;
    valid[2] = 1'b1;
    data[2] = 8'h07;
    cycle();
    valid = '0;
    repeat (70) cycle();
    for (int j = 0; j < 4; j++) push_one(0, 8'hC0 + 8'(j));
    repeat (15) cycle();
    rst_n = 1'b0;
    cycle();
    chk("midreset_tx", 0, {7'b0, tx[0]}, 8'd1);
    chk("midreset_busy", 0, {7'b0, busy[0]}, 8'd0);
    chk("midreset_count", 0, {5'b0, cnt0}, 8'd0);
    rst_n = 1'b1;
    cycle();
    push_one(0, 8'hA5);
    repeat (45) cycle();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 3; i++) begin
        valid[i] = $urandom_range(2) == 0;
        data[i] = 8'($urandom);
      end
      rst_n = $urandom_range(700) != 0;
      cycle();
    end
    rst_n = 1'b1;
    valid = '0;
    repeat (300) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_encoder.md
Name: uart_encoder

Overview:
- Bench-side UART transmitter: serializes bytes into 8N1 (optionally parity / 2-stop) frames on a single line.
- Drives the SoC's uart0_srx_pad_i so simulations can inject console input to the CPU.
- Counterpart of the existing uart_decoder, which monitors uart0_stx_pad_o.
- Synthesizable with a small byte FIFO so the stimulus side can queue strings without pacing.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); legal range >= 2.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active low
- data_i  input  8  byte to send
- valid_i  input  1  data_i valid
- ready_o  output  1  FIFO can accept; a byte is accepted when valid_i && ready_o at a rising edge
- uart_tx_o  output  1  serial line, idle high; connects to DUT uart0_srx_pad_i
- busy_o  output  1  frame in progress (start bit through last stop bit)
- frame_done_o  output  1  one-cycle pulse on the last cycle of the last stop bit
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted

Behaviour:
- Reset (rst_n low at a rising edge) forces outputs on the next edge:
  - uart_tx_o = 1, busy_o = 0, frame_done_o = 0, fifo_count_o = 0, ready_o = 1.
  - FIFO is emptied and the FSM goes to IDLE.
  - Applies mid-frame as well: the partial frame is abandoned and the line returns high immediately.
- FIFO:
  - ready_o = (fifo_count_o != FIFO_DEPTH).
  - A push while full is impossible, because ready_o is low.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. uart_tx_o is registered.
- IDLE:
  - Line is high.
  - If the FIFO is non-empty at an edge: pop the head into the shift register, clear the bit counter, go to START, and drive uart_tx_o = 0 from that edge.
  - Latency: a byte pushed into an empty FIFO at edge k appears as the start bit after edge k+1.
- START: line 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles.
  - After bit 7, go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - Even mode: bit = XOR of the data bits.
  - Odd mode: bit = inverted XOR.
  - Held CLKS_PER_BIT cycles.
- STOP:
  - Line 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done_o pulses on the final cycle.
  - At the same edge that ends STOP: if the FIFO is non-empty, pop and go directly to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- Frame length = (1 + 8 + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads on every bit boundary. It is sized $clog2(CLKS_PER_BIT)+1 bits and does not drift across frames.
- busy_o is high in START, DATA, PARITY and STOP.
- A push during a frame never disturbs the bit in flight.
- data_i is sampled only at acceptance; later changes are ignored.

Test Plan:
- CLKS_PER_BIT=4, PARITY=0. Push 0x55 at edge k:
  - line low for cycles k+1..k+4, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - frame_done_o pulses once on the cycle at k+40; busy_o is high exactly 40 cycles.
- Push 0x41, 0x0A in consecutive cycles:
  - Two frames with no idle gap: the stop bit of frame 1 is followed immediately by the start bit of frame 2.
  - fifo_count_o goes 1 → 1 → 0 around the pops.
- FIFO_DEPTH=4, push 6 bytes continuously:
  - The first is popped at once; ready_o drops after 4 more queued.
  - The 6th byte is accepted only after the next pop.
  - All 6 bytes appear on the line in order, and none is lost or duplicated.
- PARITY=2 (even), byte 0x07: parity bit = 1. PARITY=1 (odd), byte 0x07: parity bit = 0. Frame length is 11*CLKS_PER_BIT.
- Assert rst_n low during DATA bit 3 with 3 bytes queued:
  - After the next edge: uart_tx_o=1, busy_o=0, fifo_count_o=0.
  - After release, a new push of 0xA5 transmits cleanly with no leftover bytes.
- Loopback check against uart_decoder (uart_baudrate_period_ns=8680, CLKS_PER_BIT=434, 50 MHz clock): send "Hello\n" and confirm the decoder prints the identical string.
